// File: rtl/sort_toggle_master.sv
// Host-side initiator for the sorter's toggle-handshake load/unload protocol.
// It streams a block in via now1 toggles, waits for the result, then unloads it via now2 toggles.
module sort_toggle_master #(
    parameter int LOG_INPUT_NUM = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int SORT_LATENCY  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  now1,
    output logic                  now2,
    input  logic                  y_valid,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy
);

    localparam int CNT_W  = LOG_INPUT_NUM + 1;
    localparam int WAIT_W = (SORT_LATENCY < 2) ? 1 : $clog2(SORT_LATENCY + 1);
    localparam logic [CNT_W-1:0] BLOCK_N  = CNT_W'(1) << LOG_INPUT_NUM;
    localparam logic [CNT_W-1:0] LAST_IDX = BLOCK_N - CNT_W'(1);

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_LOAD_HOLD = 3'd1,
        ST_SORT_WAIT = 3'd2,
        ST_RD_REQ    = 3'd3,
        ST_RD_HOLD   = 3'd4,
        ST_RD_CAP    = 3'd5,
        ST_OUT       = 3'd6
    } state_t;

    state_t                 state_r, state_s;
    logic [CNT_W-1:0]       load_cnt_r, load_cnt_s;
    logic [CNT_W-1:0]       rd_cnt_r, rd_cnt_s;
    logic [WAIT_W-1:0]      wait_cnt_r, wait_cnt_s;
    logic [DATA_WIDTH-1:0]  din_r, din_s;
    logic [DATA_WIDTH-1:0]  m_data_r, m_data_s;
    logic                   now1_r, now1_s;
    logic                   now2_r, now2_s;
    logic                   s_ready_r, s_ready_s;
    logic                   m_valid_r, m_valid_s;
    logic                   m_last_r, m_last_s;
    logic                   busy_r, busy_s;

    // Next-state and next-output computation; every output is registered from these.
    always_comb begin
        state_s    = state_r;
        load_cnt_s = load_cnt_r;
        rd_cnt_s   = rd_cnt_r;
        wait_cnt_s = wait_cnt_r;
        din_s      = din_r;
        m_data_s   = m_data_r;
        now1_s     = now1_r;
        now2_s     = now2_r;
        m_valid_s  = m_valid_r;
        m_last_s   = m_last_r;

        case (state_r)
            ST_LOAD: begin
                if (s_valid && s_ready_r) begin
                    din_s      = s_data;
                    now1_s     = ~now1_r;
                    load_cnt_s = load_cnt_r + CNT_W'(1);
                    state_s    = ST_LOAD_HOLD;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            // din stays put here so the sorter samples it on its toggle-detect edge.
            ST_LOAD_HOLD: begin
                if (load_cnt_r == BLOCK_N) begin
                    load_cnt_s = {CNT_W{1'b0}};
                    wait_cnt_s = WAIT_W'(SORT_LATENCY);
                    state_s    = ST_SORT_WAIT;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_SORT_WAIT: begin
                if (wait_cnt_r != {WAIT_W{1'b0}}) begin
                    wait_cnt_s = wait_cnt_r - WAIT_W'(1);
                end else if (y_valid) begin
                    state_s = ST_RD_REQ;
                end else begin
                    state_s = ST_SORT_WAIT;
                end
            end
            ST_RD_REQ: begin
                now2_s  = ~now2_r;
                state_s = ST_RD_HOLD;
            end
            ST_RD_HOLD: begin
                state_s = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                m_data_s  = dout;
                m_valid_s = 1'b1;
                m_last_s  = (rd_cnt_r == LAST_IDX);
                rd_cnt_s  = rd_cnt_r + CNT_W'(1);
                state_s   = ST_OUT;
            end
            ST_OUT: begin
                if (m_ready) begin
                    m_valid_s = 1'b0;
                    m_last_s  = 1'b0;
                    if (rd_cnt_r == BLOCK_N) begin
                        rd_cnt_s = {CNT_W{1'b0}};
                        state_s  = ST_LOAD;
                    end else begin
                        state_s = ST_RD_REQ;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_LOAD;
            end
        endcase

        s_ready_s = (state_s == ST_LOAD);
        busy_s    = !((state_s == ST_LOAD) && (load_cnt_s == {CNT_W{1'b0}}));
    end

    // State and output registers; reset also discards any partial block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_LOAD;
            load_cnt_r <= {CNT_W{1'b0}};
            rd_cnt_r   <= {CNT_W{1'b0}};
            wait_cnt_r <= {WAIT_W{1'b0}};
            din_r      <= {DATA_WIDTH{1'b0}};
            m_data_r   <= {DATA_WIDTH{1'b0}};
            now1_r     <= 1'b0;
            now2_r     <= 1'b0;
            s_ready_r  <= 1'b0;
            m_valid_r  <= 1'b0;
            m_last_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            load_cnt_r <= load_cnt_s;
            rd_cnt_r   <= rd_cnt_s;
            wait_cnt_r <= wait_cnt_s;
            din_r      <= din_s;
            m_data_r   <= m_data_s;
            now1_r     <= now1_s;
            now2_r     <= now2_s;
            s_ready_r  <= s_ready_s;
            m_valid_r  <= m_valid_s;
            m_last_r   <= m_last_s;
            busy_r     <= busy_s;
        end
    end

    assign s_ready = s_ready_r;
    assign din     = din_r;
    assign now1    = now1_r;
    assign now2    = now2_r;
    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign m_last  = m_last_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_sort_toggle_master.sv
// Directed bench for sort_toggle_master with a small ascending toggle-protocol sorter model.
module tb_sort_toggle_master;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [31:0] din;
    logic        now1;
    logic        now2;
    logic        y_valid;
    logic [31:0] dout;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        busy;

    int total = 0;
    int bad   = 0;

    sort_toggle_master #(
        .LOG_INPUT_NUM(2),
        .DATA_WIDTH   (32),
        .SORT_LATENCY (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .din    (din),
        .now1   (now1),
        .now2   (now2),
        .y_valid(y_valid),
        .dout   (dout),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_last (m_last),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sorter model: captures din on now1 detect, returns the k-th smallest on now2 detect.
    logic [31:0] mem [4];
    logic        p1, p2;
    int          ld, rd;
    logic        yv_en;

    function automatic logic [31:0] kth(input int k);
        logic [31:0] a [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) a[i] = mem[i];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a[k];
    endfunction

    assign y_valid = yv_en && (ld == 4);

    always @(posedge clk) begin
        if (rst) begin
            p1 <= 1'b0; p2 <= 1'b0; ld <= 0; rd <= 0; dout <= 32'd0;
        end else begin
            p1 <= now1;
            p2 <= now2;
            if (now1 !== p1) begin
                if (ld == 4) begin
                    mem[0] <= din; ld <= 1; rd <= 0;
                end else begin
                    mem[ld] <= din; ld <= ld + 1;
                end
            end else if (now2 !== p2) begin
                dout <= kth(rd);
                rd   <= rd + 1;
            end
        end
    end

    // Protocol monitor, sampled just after each rising edge.
    int   n1_cnt, n2_cnt, col_cnt, din_bad;
    logic l_now1, l_now2, l_sready;
    logic [31:0] l_din;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            n1_cnt = 0; n2_cnt = 0; col_cnt = 0; din_bad = 0;
        end else begin
            if (now1 !== l_now1) n1_cnt++;
            if (now2 !== l_now2) n2_cnt++;
            if ((now1 !== l_now1) && (now2 !== l_now2)) col_cnt++;
            if ((din !== l_din) && !l_sready) din_bad++;
        end
        l_now1 = now1; l_now2 = now2; l_din = din; l_sready = s_ready;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        int k;
        for (k = 0; k < 100; k++) begin
            if (s_ready) break;
            @(negedge clk);
        end
        if (k == 100) chk("send_timeout", {31'd0, s_ready}, 32'd1);
        s_valid = 1'b1;
        s_data  = w;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [31:0] exp, input logic exp_last);
        for (int k = 0; k < 200; k++) begin
            if (m_valid) break;
            @(negedge clk);
        end
        chk({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
        chk({tag, "_data"}, m_data, exp);
        chk({tag, "_last"}, {31'd0, m_last}, {31'd0, exp_last});
        @(negedge clk);
    endtask

    task automatic chk_reset_values();
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_din", din, 32'd0);
        chk("rst_now1", {31'd0, now1}, 32'd0);
        chk("rst_now2", {31'd0, now2}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_m_last", {31'd0, m_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
    endtask

    int   base1, base2, cyc;
    logic stable;
    logic [31:0] held;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 32'd0; m_ready = 1'b1; yv_en = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_values();
        rst = 1'b0;

        // Block A: basic load, sort, unload
        send(32'd7);
        chk("a_din0", din, 32'd7);
        chk("a_hold_ready", {31'd0, s_ready}, 32'd0);
        chk("a_busy", {31'd0, busy}, 32'd1);
        send(32'd3);  chk("a_din1", din, 32'd3);
        send(32'd9);  chk("a_din2", din, 32'd9);
        send(32'd1);  chk("a_din3", din, 32'd1);
        recv("a0", 32'd1, 1'b0);
        recv("a1", 32'd3, 1'b0);
        recv("a2", 32'd7, 1'b0);
        recv("a3", 32'd9, 1'b1);
        chk("a_n1", n1_cnt, 32'd4);
        chk("a_n2", n2_cnt, 32'd4);
        chk("a_ready_again", {31'd0, s_ready}, 32'd1);
        chk("a_idle", {31'd0, busy}, 32'd0);

        // Block B: gaps on s_valid
        base1 = n1_cnt;
        send(32'd11);
        repeat (4) @(negedge clk);
        chk("b_gap1_n1", n1_cnt - base1, 32'd1);
        send(32'd5);
        send(32'd22);
        repeat (13) @(negedge clk);
        chk("b_gap2_n1", n1_cnt - base1, 32'd3);
        send(32'd0);
        recv("b0", 32'd0, 1'b0);
        recv("b1", 32'd5, 1'b0);
        recv("b2", 32'd11, 1'b0);
        recv("b3", 32'd22, 1'b1);
        chk("b_n1", n1_cnt - base1, 32'd4);
        chk("b_din_hold", din_bad, 32'd0);

        // Block C: y_valid held low, then backpressure on the 2nd word
        yv_en = 1'b0;
        base2 = n2_cnt;
        send(32'd30); send(32'd10); send(32'd40); send(32'd20);
        repeat (50) @(negedge clk);
        chk("c_no_unload", n2_cnt - base2, 32'd0);
        chk("c_no_mvalid", {31'd0, m_valid}, 32'd0);
        yv_en = 1'b1;
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cyc++;
            if (n2_cnt != base2) break;
        end
        chk("c_unload_latency", cyc, 32'd2);
        recv("c0", 32'd10, 1'b0);
        m_ready = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (m_valid) break;
            @(negedge clk);
        end
        held = m_data;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!m_valid || (m_data !== held)) stable = 1'b0;
        end
        chk("c_bp_data", held, 32'd20);
        chk("c_bp_stable", {31'd0, stable}, 32'd1);
        chk("c_bp_n2", n2_cnt - base2, 32'd2);
        m_ready = 1'b1;
        @(negedge clk);
        recv("c2", 32'd30, 1'b0);
        recv("c3", 32'd40, 1'b1);

        // Block D: reset after two loads, then a fresh block
        send(32'd100); send(32'd200);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_values();
        rst = 1'b0;
        send(32'hFFFF_FFFF); send(32'd0); send(32'd5); send(32'd5);
        recv("d0", 32'd0, 1'b0);
        recv("d1", 32'd5, 1'b0);
        recv("d2", 32'd5, 1'b0);
        recv("d3", 32'hFFFF_FFFF, 1'b1);
        chk("d_n1", n1_cnt, 32'd4);

        // Blocks E and F back to back
        send(32'd4); send(32'd2); send(32'd8); send(32'd6);
        recv("e0", 32'd2, 1'b0);
        recv("e1", 32'd4, 1'b0);
        recv("e2", 32'd6, 1'b0);
        recv("e3", 32'd8, 1'b1);
        send(32'd1); send(32'd1); send(32'd0); send(32'd3);
        recv("f0", 32'd0, 1'b0);
        recv("f1", 32'd1, 1'b0);
        recv("f2", 32'd1, 1'b0);
        recv("f3", 32'd3, 1'b1);
        chk("ef_n1", n1_cnt, 32'd12);
        chk("ef_n2", n2_cnt, 32'd12);
        chk("ef_collision", col_cnt, 32'd0);
        chk("ef_din_hold", din_bad, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
